// File: rtl/iic_write8.sv
// iic_write8: shifts one byte out on SDA, MSB first, then samples the
// slave's ACK bit. SCL timing comes from an external divider through the
// scl_lc (centre of the low phase) and scl_hc (centre of the high phase)
// strobes. START/STOP conditions are generated elsewhere.
module iic_write8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       scl_lc,
    input  logic       scl_hc,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_out,
    output logic       sdalink,
    output logic       busy,
    output logic       done,
    output logic       ack_ok
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TX   = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    logic [1:0] state_reg;
    logic [7:0] shreg_reg;
    logic [2:0] bcnt_reg;
    logic       bit_valid_reg;
    logic       sda_out_reg;
    logic       sdalink_reg;
    logic       ack_ok_reg;

    // A strobe only counts when the SCL level agrees with it; this also
    // resolves the case where both strobes arrive in the same cycle.
    logic lc_ok;
    logic hc_ok;
    assign lc_ok = scl_lc & ~scl;
    assign hc_ok = scl_hc & scl;

    // Byte transmit state machine: present a bit in each low phase, count it
    // in the following high phase, then release SDA and sample the ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            shreg_reg     <= 8'h00;
            bcnt_reg      <= 3'd7;
            bit_valid_reg <= 1'b0;
            sda_out_reg   <= 1'b1;
            sdalink_reg   <= 1'b0;
            ack_ok_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    sdalink_reg <= 1'b0;
                    if (start) begin
                        shreg_reg     <= data_in;
                        bcnt_reg      <= 3'd7;
                        bit_valid_reg <= 1'b0;
                        state_reg     <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (lc_ok) begin
                        sdalink_reg   <= 1'b1;
                        sda_out_reg   <= shreg_reg[bcnt_reg];
                        bit_valid_reg <= 1'b1;
                    end else if (hc_ok && bit_valid_reg) begin
                        // A high-phase strobe before the bit was presented
                        // is not counted (bit_valid_reg gates it).
                        bit_valid_reg <= 1'b0;
                        if (bcnt_reg == 3'd0) begin
                            state_reg <= ST_ACK;
                        end else begin
                            bcnt_reg <= bcnt_reg - 3'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (lc_ok) begin
                        // Release SDA for the slave; park sda_out at its idle
                        // level here so it only ever moves during SCL low.
                        sdalink_reg   <= 1'b0;
                        sda_out_reg   <= 1'b1;
                        bit_valid_reg <= 1'b1;
                    end else if (hc_ok && bit_valid_reg) begin
                        ack_ok_reg    <= ~sda;
                        bit_valid_reg <= 1'b0;
                        state_reg     <= ST_FIN;
                    end
                end
                default: begin
                    // ST_FIN: one-cycle done; a start here is ignored.
                    sdalink_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign sda_out = sda_out_reg;
    assign sdalink = sdalink_reg;
    assign ack_ok  = ack_ok_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_FIN);

endmodule

// File: tb/tb_iic_write8.sv
// Bench for iic_write8: a table of directed transfers, a reset-mid-byte
// sequence, then randomized transfers. Expected bits come from a queue
// filled from the byte (MSB first) and compared at each SCL high centre.
module tb_iic_write8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       scl_lc;
    logic       scl_hc;
    logic       scl;
    logic       sda;
    logic       sda_out;
    logic       sdalink;
    logic       busy;
    logic       done;
    logic       ack_ok;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    iic_write8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .scl_lc  (scl_lc),
        .scl_hc  (scl_hc),
        .scl     (scl),
        .sda     (sda),
        .sda_out (sda_out),
        .sdalink (sdalink),
        .busy    (busy),
        .done    (done),
        .ack_ok  (ack_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic [7:0] data;
        bit         ack_sda;
        bit         noise;
        bit         early_hc;
        int         mid_start;
        bit         fin_start;
        bit         exp_ack;
    } vec_t;

    bit exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One SCL period. With noise set, mismatched and simultaneous strobes
    // are injected, which must have no effect.
    task automatic scl_period(input bit noise, input bit slave_sda,
                              output bit obs_link, output bit obs_val, output bit obs_done);
        logic hold_val;
        scl = 1'b0; sda = 1'b1; scl_lc = 1'b0; scl_hc = 1'b0;
        @(negedge clk); scl_hc = noise;
        @(negedge clk); scl_hc = noise; scl_lc = 1'b1;
        @(negedge clk); scl_lc = 1'b0; scl_hc = 1'b0;
        @(negedge clk); scl = 1'b1; sda = slave_sda;
        @(negedge clk); scl_lc = noise; hold_val = sda_out;
        @(negedge clk); scl_lc = noise; scl_hc = 1'b1;
        obs_link = sdalink;
        obs_val  = sdalink ? sda_out : sda;
        chk("sda_out_stable_high", sda_out, hold_val);
        @(negedge clk); scl_lc = 1'b0; scl_hc = 1'b0;
        obs_done = done;
    endtask

    task automatic do_byte(input vec_t v);
        bit   link, val, dn;
        int   done_before;
        done_before = done_cnt;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(v.data[i]);

        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        start = 1'b1; data_in = v.data;
        @(negedge clk);
        start = 1'b0; data_in = 8'($urandom);
        chk("busy_after_start", busy, 1'b1);

        if (v.early_hc) begin
            scl = 1'b1; scl_hc = 1'b1;
            @(negedge clk); scl_hc = 1'b0;
        end

        for (int i = 0; i < 8; i++) begin
            scl_period(v.noise, 1'b1, link, val, dn);
            chk("data_link", link, 1'b1);
            chk("data_bit", val, exp_q.pop_front());
            chk("no_done_in_data", dn, 1'b0);
            if (i == v.mid_start) begin
                start = 1'b1; data_in = 8'hFF;
                @(negedge clk);
                start = 1'b0;
                chk("busy_ignores_start", busy, 1'b1);
            end
        end

        scl_period(v.noise, v.ack_sda, link, val, dn);
        chk("ack_link_released", link, 1'b0);
        chk("done_latency", dn, 1'b1);
        chk("ack_ok", ack_ok, v.exp_ack);
        if (v.fin_start) begin
            start = 1'b1; data_in = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        chk("busy_dropped", busy, 1'b0);
        chk("done_count", done_cnt - done_before, 1);
        $display("xfer data=%02h ack_sda=%0b noise=%0b early=%0b mid=%0d fin=%0b ack_ok=%0b",
                 v.data, v.ack_sda, v.noise, v.early_hc, v.mid_start, v.fin_start, ack_ok);
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        bit link, val, dn;
        rst = 1'b1; start = 1'b1; data_in = 8'hAA;
        scl = 1'b0; sda = 1'b1; scl_lc = 1'b0; scl_hc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sdalink", sdalink, 1'b0);
        chk("rst_sda_out", sda_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_ok", ack_ok, 1'b0);
        rst = 1'b0; start = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1};
        vecs[1] = '{8'h80, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1};
        vecs[3] = '{8'hC3, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1,  4, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) do_byte(vecs[k]);

        // Reset after the third counted bit, with start held during reset.
        @(negedge clk);
        start = 1'b1; data_in = 8'h96;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) scl_period(1'b0, 1'b1, link, val, dn);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("midrst_sdalink", sdalink, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_sda_out", sda_out, 1'b1);
        chk("midrst_ack_ok", ack_ok, 1'b0);
        $display("xfer data=96 reset after 3 bits");
        do_byte('{8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1});

        for (int k = 0; k < 20; k++) begin
            rv.data      = 8'($urandom);
            rv.ack_sda   = 1'($urandom_range(0, 1));
            rv.noise     = 1'($urandom_range(0, 1));
            rv.early_hc  = 1'($urandom_range(0, 1));
            rv.mid_start = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            rv.fin_start = 1'($urandom_range(0, 1));
            rv.exp_ack   = ~rv.ack_sda;
            do_byte(rv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
